// File: rtl/mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mult_issue_ctrl
//
// Issue/capture stage in front of a fixed-latency N x N signed multiplier core.
// An operand pair is accepted on a valid/ready input and registered onto the
// core's operand inputs. The stage pulses the core's start, waits a fixed
// number of cycles, captures the 2N-bit product, and presents it on a
// valid/ready output. Only one operation is in flight at a time, so the core
// is never restarted while it is busy.
//
// Parameters
//   N          operand width; the product is 2N bits
//   START_LEN  cycles mul_start is held high per operation (>= 1)
//   LATENCY    cycles from mul_start falling to the product sample (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active high
//   in_valid     operand pair valid
//   in_ready     stage can accept a pair (high only in IDLE)
//   in_a, in_b   signed multiplicand / multiplier
//   mul_a, mul_b registered operands to the multiplier core
//   mul_start    start strobe to the multiplier core
//   mul_product  product from the multiplier core
//   out_valid    captured product valid
//   out_ready    downstream accepts the product
//   out_product  captured signed product (full 2N bits)
//   busy         high in any state other than IDLE
//   out_ovf      (only with MULT_ISSUE_OVF_EN) product does not fit in N bits
//
// Build option
//   MULT_ISSUE_OVF_EN  when defined, adds the out_ovf output and its register.
//
// Timing: the accept edge registers the operands; mul_start rises on the next
// edge so the core sees stable operands before it starts. Accept edge to
// out_valid rising is therefore 1 + START_LEN + LATENCY cycles.
// -----------------------------------------------------------------------------
module mult_issue_ctrl #(
    parameter int N         = 32,
    parameter int START_LEN = 2,
    parameter int LATENCY   = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    output logic             mul_start,
    input  logic [2*N-1:0]   mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_product,
`ifdef MULT_ISSUE_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int CNT_MAX = (LATENCY > START_LEN) ? LATENCY : START_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] START_END_C = CW'(START_LEN);
    localparam logic [CW-1:0] WAIT_LAST_C = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    mul_a_q;
    logic [N-1:0]    mul_b_q;
    logic            mul_start_q;
    logic            in_ready_q;
    logic            busy_q;
    logic            out_valid_q;
    logic [2*N-1:0]  out_product_q;

`ifdef MULT_ISSUE_OVF_EN
    logic            out_ovf_q;
    logic            ovf_d;

    // The product fits in signed N bits only when its top N+1 bits are all
    // copies of the sign bit.
    always_comb begin
        ovf_d = ~((&mul_product[2*N-1:N-1]) | ~(|mul_product[2*N-1:N-1]));
    end

    assign out_ovf = out_ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_start_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
`ifdef MULT_ISSUE_OVF_EN
            out_ovf_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mul_a_q    <= in_a;
                        mul_b_q    <= in_b;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                // First START cycle presents operands only; mul_start is then
                // high for START_LEN cycles (counts 0..START_LEN-1).
                S_START: begin
                    if (cnt_q == START_END_C) begin
                        mul_start_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_WAIT;
                    end else begin
                        mul_start_q <= 1'b1;
                        cnt_q       <= cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST_C) begin
                        out_product_q <= mul_product;
`ifdef MULT_ISSUE_OVF_EN
                        out_ovf_q     <= ovf_d;
`endif
                        out_valid_q   <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                // Retiring returns to IDLE; a pair offered in this same cycle
                // is taken on the following edge (no bypass).
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_start   = mul_start_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_issue_ctrl
//
// Scoreboard bench for mult_issue_ctrl. A behavioural multiplier drives
// mul_product from mul_a/mul_b. The monitor keeps a transaction-level model
// (operation in flight, cycles since accept, last accepted operands) and a
// queue of expected products computed from the offered in_a/in_b (or from
// fixed reference constants for the directed vectors).
// -----------------------------------------------------------------------------
module tb_mult_issue_ctrl;

    localparam int SL  = 2;
    localparam int LAT = 100;
    localparam int TOT = 1 + SL + LAT;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_a;
    logic [31:0]  in_b;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic         mul_start;
    logic [63:0]  mul_product;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_product;
    logic         busy;
`ifdef MULT_ISSUE_OVF_EN
    logic         out_ovf;
`endif

    mult_issue_ctrl #(.N(32), .START_LEN(SL), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
`ifdef MULT_ISSUE_OVF_EN
        .out_ovf     (out_ovf),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier core
    assign mul_product = longint'($signed(mul_a)) * longint'($signed(mul_b));

    typedef struct packed {
        logic [63:0] prod;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_inflight = 1'b0;
    int          m_k = 0;
    logic [31:0] m_last_a = '0;
    logic [31:0] m_last_b = '0;
    int          txn_n = 0;

    bit          dir_en = 1'b0;
    logic [63:0] dir_prod = '0;
    bit          rdy_force = 1'b1;
    bit          rdy_val = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ovf_of(input logic [63:0] p);
        longint s;
        s = longint'(p);
        return (s > longint'(2147483647)) || (s < -longint'(2147483647) - 1);
    endfunction

    // Monitor / scoreboard: sample at the falling edge, predict next edge.
    always @(negedge clk) begin
        bit     prev_inflight;
        bit     exp_ov;
        longint p;
        exp_t   e;
        if (rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_mul_start", mul_start, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_mul_a", mul_a, 0);
            chk("rst_mul_b", mul_b, 0);
            chk("rst_out_product", out_product, 0);
            sb_q.delete();
            m_inflight = 1'b0;
            m_k        = 0;
            m_last_a   = '0;
            m_last_b   = '0;
        end else begin
            prev_inflight = m_inflight;
            exp_ov = prev_inflight && (m_k >= TOT);
            chk("in_ready", in_ready, !prev_inflight);
            chk("busy", busy, prev_inflight);
            chk("mul_start", mul_start, prev_inflight && m_k >= 1 && m_k <= SL);
            chk("out_valid", out_valid, exp_ov);
            chk("mul_a", mul_a, m_last_a);
            chk("mul_b", mul_b, m_last_b);
            if (out_valid && sb_q.size() > 0) begin
                chk("out_product", out_product, sb_q[0].prod);
`ifdef MULT_ISSUE_OVF_EN
                chk("out_ovf", out_ovf, sb_q[0].ovf);
`endif
            end
            if (exp_ov && out_ready) begin
                if (sb_q.size() > 0) begin
                    txn_n++;
                    $display("TXN %0d retire product=%h t=%0t", txn_n, sb_q[0].prod, $time);
                    void'(sb_q.pop_front());
                end
                m_inflight = 1'b0;
            end else if (prev_inflight) begin
                m_k++;
            end
            if (!prev_inflight && in_valid) begin
                p      = longint'($signed(in_a)) * longint'($signed(in_b));
                e.prod = dir_en ? dir_prod : p;
                e.ovf  = ovf_of(e.prod);
                sb_q.push_back(e);
                m_inflight = 1'b1;
                m_k        = 0;
                m_last_a   = in_a;
                m_last_b   = in_b;
            end
        end
    end

    // Downstream ready: random unless forced by the directed sequence.
    always begin
        @(posedge clk);
        #2;
        out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 600) begin
                checks++; errors++;
                $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high t=%0t", $time);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input bit de, input logic [63:0] dp);
        in_a = a; in_b = b; dir_en = de; dir_prod = dp; in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        dir_en   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!m_inflight && sb_q.size() == 0) break;
            n++;
            if (n > 1000) begin
                checks++; errors++;
                $display("FAIL idle_timeout actual=pending%0d required=pending0 t=%0t", sb_q.size(), $time);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed reference vectors
        send(32'h00087234, 32'h00000348, 1'b1, 64'h000000001BB6BAA0);
        wait_idle();
        send(32'h00087234, 32'hFFFFFEFD, 1'b1, 64'hFFFFFFFFF7747564);
        wait_idle();
        send(32'h50647236, 32'h50612336, 1'b1, 64'h193DE4CED7437964);
        wait_idle();

        // Hold the result for 20 cycles while offering a new pair
        rdy_force = 1'b1; rdy_val = 1'b0;
        send($urandom, $urandom, 1'b0, '0);
        begin
            int n = 0;
            while (!out_valid && n < 300) begin @(negedge clk); n++; end
            if (!out_valid) begin
                checks++; errors++;
                $display("FAIL hold_wait actual=0 required=1 t=%0t", $time);
            end
        end
        @(posedge clk); #1;
        in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 rdy_val = 1'b1;
        wait_accept();
        in_valid  = 1'b0;
        rdy_force = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of WAIT
        rdy_force = 1'b1; rdy_val = 1'b1;
        send(32'h12345678, 32'h00000005, 1'b0, '0);
        repeat (50) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_mul_a", mul_a, 0);
        chk("async_rst_mul_b", mul_b, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_mul_start", mul_start, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send(32'hB887CAAF, 32'h00000001, 1'b1, 64'hFFFFFFFFB887CAAF);
        wait_idle();

        // Back-to-back with in_valid held high
        rdy_force = 1'b0;
        in_a = 32'h0; in_b = 32'h50647236; dir_en = 1'b1; dir_prod = 64'h0;
        in_valid = 1'b1;
        wait_accept();
        dir_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_a = rnd_op(); in_b = rnd_op();
            wait_accept();
        end
        in_valid = 1'b0;
        wait_idle();

        // Isolated random operations with random gaps
        for (int i = 0; i < 6; i++) begin
            send(rnd_op(), rnd_op(), 1'b0, '0);
            repeat ($urandom_range(0, 150)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        checks++; errors++;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
